player_mover: RTL



---
 rtl/player_pkg.sv | 32 +++
 rtl/player_corner_gen.sv | 26 ++
 rtl/player_mover.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared types and fixed-point helpers for the player position controller.
// Positions are unsigned fixed point: 11 integer bits . 7 fraction bits.
package player_pkg;

  localparam int unsigned POS_W = 18;
  localparam int unsigned FRAC  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Hitbox corner index: bit 0 selects the right edge, bit 1 the bottom edge.
  typedef logic [1:0] corner_t;

  typedef logic [POS_W-1:0] fx_t;

  // Saturating add: clamps at the all-ones position instead of wrapping.
  function automatic fx_t clamp_add(input fx_t a, input fx_t b);
    logic [POS_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[POS_W] ? '1 : sum[POS_W-1:0];
  endfunction

  // Saturating subtract: clamps at zero instead of wrapping.
  function automatic fx_t clamp_sub(input fx_t a, input fx_t b);
    return (a < b) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/player_corner_gen.sv
// Hitbox corner generator: maps a candidate integer position and a corner
// index to the pixel probed in the map. Offsets wrap at the integer width.
module player_corner_gen
  import player_pkg::*;
#(
  parameter int unsigned INT_W = 11,
  parameter int unsigned SIZE  = 20
) (
  input  logic [INT_W-1:0] cand_x,
  input  logic [INT_W-1:0] cand_y,
  input  corner_t          k,
  output logic [INT_W-1:0] probe_x,
  output logic [INT_W-1:0] probe_y
);

  localparam logic [INT_W-1:0] EDGE = INT_W'(SIZE - 1);

  // Corner k: bit 0 pushes X to the far edge, bit 1 pushes Y to the far edge.
  always_comb begin
    probe_x = cand_x;
    probe_y = cand_y;
    if (k[0]) probe_x = cand_x + EDGE;
    if (k[1]) probe_y = cand_y + EDGE;
  end

endmodule

// File: rtl/player_mover.sv
// Player position controller. On each accepted tick it builds a candidate
// position, probes the four hitbox corners through the shared wall lookup
// one per cycle, and commits the move only if every corner is clear.
// Build option: define PLAYER_DIAG_EN to allow both axes to move in one tick;
// otherwise a single axis moves with priority up > down > left > right.
module player_mover #(
  parameter int unsigned      POS_W = 18,
  parameter int unsigned      FRAC  = 7,
  parameter logic [POS_W-1:0] STEP  = 18'd128,
  parameter int unsigned      SIZE  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [POS_W-1:0]      start_x,
  input  logic [POS_W-1:0]      start_y,
  input  logic                  tick,
  input  logic                  dir_up,
  input  logic                  dir_down,
  input  logic                  dir_left,
  input  logic                  dir_right,
  output logic [POS_W-FRAC-1:0] probe_x,
  output logic [POS_W-FRAC-1:0] probe_y,
  input  logic                  wall,
  output logic [POS_W-FRAC-1:0] pos_x,
  output logic [POS_W-FRAC-1:0] pos_y,
  output logic                  busy,
  output logic                  bump,
  output logic [15:0]           move_count
);

  import player_pkg::*;

  localparam int unsigned INT_W = POS_W - FRAC;

  state_t               state, state_nx;
  logic [POS_W-1:0]     pos_fx_x, pos_fx_y;
  logic [POS_W-1:0]     cand_fx_x, cand_fx_y;
  logic [POS_W-1:0]     cand_nx_x, cand_nx_y;
  corner_t              k;
  logic                 blocked;
  // Requested motion, packed as {up, down, left, right}.
  logic [3:0]           req, req_q;
  logic [INT_W-1:0]     corner_x, corner_y;

  // Resolve the button levels into the motion requested for this tick.
  always_comb begin
    logic net_up, net_down, net_left, net_right;
    net_up    = dir_up    & ~dir_down;
    net_down  = dir_down  & ~dir_up;
    net_left  = dir_left  & ~dir_right;
    net_right = dir_right & ~dir_left;
    req = '0;
`ifdef PLAYER_DIAG_EN
    req = {net_up, net_down, net_left, net_right};
`else
    if (net_up)         req = 4'b1000;
    else if (net_down)  req = 4'b0100;
    else if (net_left)  req = 4'b0010;
    else if (net_right) req = 4'b0001;
`endif
  end

  // Candidate position from the latched request, clamped at both ends.
  always_comb begin
    cand_nx_x = pos_fx_x;
    cand_nx_y = pos_fx_y;
    if (req_q[3])      cand_nx_y = clamp_sub(pos_fx_y, STEP);
    else if (req_q[2]) cand_nx_y = clamp_add(pos_fx_y, STEP);
    if (req_q[1])      cand_nx_x = clamp_sub(pos_fx_x, STEP);
    else if (req_q[0]) cand_nx_x = clamp_add(pos_fx_x, STEP);
  end

  player_corner_gen #(
    .INT_W (INT_W),
    .SIZE  (SIZE)
  ) u_corner (
    .cand_x  (cand_fx_x[POS_W-1:FRAC]),
    .cand_y  (cand_fx_y[POS_W-1:FRAC]),
    .k       (k),
    .probe_x (corner_x),
    .probe_y (corner_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    bump     = 1'b0;
    case (state)
      IDLE:  if (tick && (req != '0)) state_nx = CALC;
      CALC:  state_nx = PROBE;
      PROBE: if (wall || (k == 2'd3)) state_nx = DONE;
      DONE: begin
        bump     = blocked;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch request, hold candidate, step corners, commit on DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_fx_x   <= start_x;
      pos_fx_y   <= start_y;
      cand_fx_x  <= start_x;
      cand_fx_y  <= start_y;
      req_q      <= '0;
      k          <= '0;
      blocked    <= 1'b0;
      move_count <= '0;
    end else begin
      case (state)
        IDLE: if (tick && (req != '0)) req_q <= req;
        CALC: begin
          cand_fx_x <= cand_nx_x;
          cand_fx_y <= cand_nx_y;
          k         <= '0;
          blocked   <= 1'b0;
        end
        PROBE: begin
          if (wall)           blocked <= 1'b1;
          else if (k != 2'd3) k       <= k + 2'd1;
        end
        DONE: begin
          if (!blocked) begin
            pos_fx_x <= cand_fx_x;
            pos_fx_y <= cand_fx_y;
            if (move_count != '1) move_count <= move_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Probe shows the active corner while probing, else tracks the player.
  always_comb begin
    probe_x = pos_fx_x[POS_W-1:FRAC];
    probe_y = pos_fx_y[POS_W-1:FRAC];
    if (state == PROBE) begin
      probe_x = corner_x;
      probe_y = corner_y;
    end
  end

  assign pos_x = pos_fx_x[POS_W-1:FRAC];
  assign pos_y = pos_fx_y[POS_W-1:FRAC];

endmodule
